multicycle_controller: RTL and testbench

Moore-FSM control unit for the multicycle MIPS datapath. Sequences instruction fetch, the Register_File (A1/A2 reads, WE3 write via RegWrite), the ALU, memory and PC over 3-5 cycles per instruction. Takes Op/Funct from the instruction register and Zero from the ALU. Drives every datapath enable and mux select.

---
 rtl/mc_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_controller_alu_decoder.sv | 24 ++
 rtl/multicycle_controller.sv | 157 +++++++++++++++
 tb/tb_multicycle_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct fields, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALURESULT = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_JUMP      = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct decoder: ALU operation plus a flag telling DECODE whether
// the funct field names a supported instruction.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_funct_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FUNCT_ADD: o_alu_control = ALU_ADD;
            FUNCT_SUB: o_alu_control = ALU_SUB;
            FUNCT_AND: o_alu_control = ALU_AND;
            FUNCT_OR:  o_alu_control = ALU_OR;
            FUNCT_SLT: o_alu_control = ALU_SLT;
            default:   o_funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath (lw, sw, R-type,
// beq, addi, j); illegal instructions either skip or park in HALT.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_state;
    logic [2:0] w_alu_funct;
    logic       w_funct_valid;
    logic       w_instr_illegal;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .i_funct       (Funct),
        .o_alu_control (w_alu_funct),
        .o_funct_valid (w_funct_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_instr_illegal = 1'b1;
        case (Op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_instr_illegal = 1'b0;
            OP_RTYPE: w_instr_illegal = !w_funct_valid;
            default:  w_instr_illegal = 1'b1;
        endcase
    end

    // During reset the datapath sees FETCH selects with all enables gated off.
    assign w_dec_state = RST ? S_FETCH : r_state;

    always_comb begin
        w_next      = S_FETCH;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUControl  = ALU_ADD;
        PCSrc       = PC_ALURESULT;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                if (w_instr_illegal) begin
                    w_illegal = 1'b1;
                    w_next    = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    case (Op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_EXECUTE;
                        OP_BEQ:       w_next = S_BRANCH;
                        OP_ADDI:      w_next = S_ADDIEX;
                        OP_J:         w_next = S_JUMP;
                        default:      w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_B;
                ALUControl = w_alu_funct;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                w_branch   = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                PCSrc      = PC_JUMP;
                w_pc_write = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    assign MemWrite = !RST && w_mem_write;
    assign IRWrite  = !RST && w_ir_write;
    assign RegWrite = !RST && w_reg_write;
    assign PCEn     = !RST && (w_pc_write || (w_branch && Zero));
    assign Illegal  = !RST && w_illegal;
    assign State    = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: table of per-cycle vectors for
// each instruction class plus hand sequences for reset and HALT.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       iord0, mw0, irw0, rd0, m2r0, rw0, srca0, pcen0, ill0;
    logic [1:0] srcb0, pcs0;
    logic [2:0] aluc0;
    logic [3:0] st0;
    logic       iord1, mw1, irw1, rd1, m2r1, rw1, srca1, pcen1, ill1;
    logic [1:0] srcb1, pcs1;
    logic [2:0] aluc1;
    logic [3:0] st1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .Op(op), .Funct(funct), .Zero(zero),
        .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .RegDst(rd0),
        .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(srca0), .ALUSrcB(srcb0),
        .ALUControl(aluc0), .PCSrc(pcs0), .PCEn(pcen0), .Illegal(ill0),
        .State(st0)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .Op(op), .Funct(funct), .Zero(zero),
        .IorD(iord1), .MemWrite(mw1), .IRWrite(irw1), .RegDst(rd1),
        .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(srca1), .ALUSrcB(srcb1),
        .ALUControl(aluc1), .PCSrc(pcs1), .PCEn(pcen1), .Illegal(ill1),
        .State(st1)
    );

    // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn,Illegal}
    function automatic logic [16:0] mk(input logic iord, mw, irw, rd, m2r, rw, srca,
                                       input logic [1:0] srcb, input logic [2:0] aluc,
                                       input logic [1:0] pcs, input logic pcen, ill);
        return {iord, mw, irw, rd, m2r, rw, srca, srcb, aluc, pcs, pcen, ill};
    endfunction

    function automatic logic [16:0] act0();
        return {iord0, mw0, irw0, rd0, m2r0, rw0, srca0, srcb0, aluc0, pcs0, pcen0, ill0};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [16:0] ex;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] s, input logic [16:0] e);
        vec_t v;
        v.name = name; v.op = o; v.funct = f; v.zero = z; v.st = s; v.ex = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [16:0] e_fetch, e_dec, e_dec_ill, e_rst;
        e_fetch   = mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0);
        e_dec     = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        e_dec_ill = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
        e_rst     = mk(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);

        // lw
        add("lw_f",   6'b100011, 6'b111111, 0, 4'd0, e_fetch);
        add("lw_d",   6'b100011, 6'b111111, 0, 4'd1, e_dec);
        add("lw_adr", 6'b100011, 6'b111111, 1, 4'd2, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        add("lw_rd",  6'b100011, 6'b111111, 0, 4'd3, mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
        add("lw_wb",  6'b100011, 6'b111111, 0, 4'd4, mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0));
        // R-type sub, slt, or
        add("sub_f",  6'b000000, 6'b100010, 0, 4'd0, e_fetch);
        add("sub_d",  6'b000000, 6'b100010, 0, 4'd1, e_dec);
        add("sub_ex", 6'b000000, 6'b100010, 0, 4'd6, mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0));
        add("sub_wb", 6'b000000, 6'b100010, 0, 4'd7, mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0));
        add("slt_f",  6'b000000, 6'b101010, 0, 4'd0, e_fetch);
        add("slt_d",  6'b000000, 6'b101010, 0, 4'd1, e_dec);
        add("slt_ex", 6'b000000, 6'b101010, 0, 4'd6, mk(0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0));
        add("slt_wb", 6'b000000, 6'b101010, 0, 4'd7, mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0));
        add("or_f",   6'b000000, 6'b100101, 0, 4'd0, e_fetch);
        add("or_d",   6'b000000, 6'b100101, 0, 4'd1, e_dec);
        add("or_ex",  6'b000000, 6'b100101, 0, 4'd6, mk(0,0,0,0,0,0,1,2'b00,3'b001,2'b00,0,0));
        add("or_wb",  6'b000000, 6'b100101, 0, 4'd7, mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0));
        // beq taken (Zero high throughout, DECODE must still keep PCEn low)
        add("beqt_f", 6'b000100, 6'b000000, 1, 4'd0, e_fetch);
        add("beqt_d", 6'b000100, 6'b000000, 1, 4'd1, e_dec);
        add("beqt_b", 6'b000100, 6'b000000, 1, 4'd8, mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        // beq not taken
        add("beqn_f", 6'b000100, 6'b000000, 0, 4'd0, e_fetch);
        add("beqn_d", 6'b000100, 6'b000000, 0, 4'd1, e_dec);
        add("beqn_b", 6'b000100, 6'b000000, 0, 4'd8, mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0));
        // addi
        add("addi_f", 6'b001000, 6'b000000, 0, 4'd0, e_fetch);
        add("addi_d", 6'b001000, 6'b000000, 0, 4'd1, e_dec);
        add("addi_x", 6'b001000, 6'b000000, 0, 4'd9, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        add("addi_w", 6'b001000, 6'b000000, 0, 4'd10, mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0));
        // sw
        add("sw_f",   6'b101011, 6'b000000, 0, 4'd0, e_fetch);
        add("sw_d",   6'b101011, 6'b000000, 0, 4'd1, e_dec);
        add("sw_adr", 6'b101011, 6'b000000, 0, 4'd2, mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        add("sw_wr",  6'b101011, 6'b000000, 0, 4'd5, mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
        // j
        add("j_f",    6'b000010, 6'b000000, 0, 4'd0, e_fetch);
        add("j_d",    6'b000010, 6'b000000, 0, 4'd1, e_dec);
        add("j_j",    6'b000010, 6'b000000, 0, 4'd11, mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0));
        // illegal R funct, then illegal opcode (dut1 halts from here on)
        add("ilf_f",  6'b000000, 6'b000001, 0, 4'd0, e_fetch);
        add("ilf_d",  6'b000000, 6'b000001, 0, 4'd1, e_dec_ill);
        add("ilo_f",  6'b111111, 6'b000000, 0, 4'd0, e_fetch);
        add("ilo_d",  6'b111111, 6'b000000, 0, 4'd1, e_dec_ill);
        add("ilo_nx", 6'b111111, 6'b000000, 0, 4'd0, e_fetch);

        // Reset for two cycles
        rst = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(st0), 32'd0);
        check("rst_outs", 32'(act0()), 32'(e_rst));
        rst = 1'b0;
        @(negedge clk);
        check("rel_fetch", 32'(act0()), 32'(e_fetch));

        // lw up to MEMWB, then reset in the writeback cycle
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_state", 32'(st0), 32'd4);
        check("mid_regwr", 32'(rw0), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_outs", 32'(act0()), 32'(e_rst));
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_state", 32'(st0), 32'd0);

        foreach (vecs[i]) begin
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            @(negedge clk);
            check({vecs[i].name, "_state"}, 32'(st0), 32'(vecs[i].st));
            check({vecs[i].name, "_outs"}, 32'(act0()), 32'(vecs[i].ex));
            @(posedge clk);
            #1;
        end

        // dut1 must sit in HALT with every enable low
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("halt_state", 32'(st1), 32'd12);
            check("halt_enables", 32'({mw1, irw1, rw1, pcen1, ill1}), 32'd0);
            @(posedge clk);
            #1;
        end

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("halt_rst_state", 32'(st1), 32'd0);
        check("dut0_rst_state", 32'(st0), 32'd0);
        @(negedge clk);
        check("halt_rel_irw", 32'(irw1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
